// File: rtl/bus_fifo_pkg.sv
// Shared defaults and limits for the bus_fifo block and its storage.
package bus_fifo_pkg;
    localparam int DEPTH_DEF = 4;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_MAX = 16;
endpackage

// File: rtl/bus_fifo_if.sv
// Valid/ready bus around the FIFO: upstream s_* side and downstream m_* side.
//
// Handshake: a word moves on a rising clock edge where valid && ready. A
// producer holds data stable while valid is high and ready is low; valid
// never waits on ready.
interface bus_fifo_if #(
    parameter int DW = bus_fifo_pkg::DW_DEF
);
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    // The FIFO itself sits on the slave side of both streams.
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );

    // Producer and consumer stages around the FIFO.
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );
endinterface

// File: rtl/bus_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
// Contents are never cleared; the control logic decides what is visible.
module bus_fifo_mem #(
    parameter  int DEPTH = bus_fifo_pkg::DEPTH_DEF,
    parameter  int DW    = bus_fifo_pkg::DW_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/bus_fifo.sv
// Valid/ready FIFO with occupancy, peak-occupancy and transfer counters.
// No pass-through: a pushed word is visible one cycle later at the earliest.
module bus_fifo
    import bus_fifo_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int DW    = DW_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    bus_fifo_if.slave     bus,
    output logic [CW-1:0] count,
    output logic [CW-1:0] high_water,
    output logic [31:0]   xfer_cnt
);
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] hw_q, hw_d;
    logic [31:0]   xfer_cnt_q, xfer_cnt_d;
    logic          push, pop;

    assign bus.s_ready = (count_q != CW'(DEPTH));
    assign bus.m_valid = (count_q != '0);

    assign push = bus.s_valid && bus.s_ready;
    assign pop  = bus.m_valid && bus.m_ready;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        hw_d       = hw_q;
        xfer_cnt_d = xfer_cnt_q;
        // Flush drops any same-cycle push/pop but keeps the transfer count.
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            hw_d    = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d     = rptr_q + 1'b1;
                xfer_cnt_d = xfer_cnt_q + 32'd1;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
            if (count_d > hw_q) begin
                hw_d = count_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            hw_q       <= '0;
            xfer_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            hw_q       <= hw_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    bus_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push && !flush && !rst),
        .waddr_i (wptr_q),
        .wdata_i (bus.s_data),
        .raddr_i (rptr_q),
        .rdata_o (bus.m_data)
    );

    assign count      = count_q;
    assign high_water = hw_q;
    assign xfer_cnt   = xfer_cnt_q;
endmodule

// File: tb/tb_bus_fifo.sv
// Directed and random checks of bus_fifo against a queue-based reference model.
module tb_bus_fifo;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] count;
    logic [CW-1:0] high_water;
    logic [31:0]   xfer_cnt;

    bus_fifo_if #(.DW(DW)) bus ();

    bus_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .count      (count),
        .high_water (high_water),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: stored words in push order, peak occupancy, pop count.
    logic [DW-1:0] exp_q[$];
    int            exp_hw;
    logic [31:0]   exp_xfer;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("high_water", 32'(high_water), 32'(exp_hw));
        chk("xfer_cnt", xfer_cnt, exp_xfer);
        chk("s_ready", 32'(bus.s_ready), 32'(exp_q.size() != DEPTH));
        chk("m_valid", 32'(bus.m_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, check at the next falling edge.
    task automatic step(input logic rs, input logic fl, input logic sv,
                        input logic [DW-1:0] sd, input logic mr);
        bit do_push;
        bit do_pop;
        rst         = rs;
        flush       = fl;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        do_push = sv && (exp_q.size() < DEPTH);
        do_pop  = mr && (exp_q.size() > 0);
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            exp_hw   = 0;
            exp_xfer = '0;
        end else if (fl) begin
            exp_q.delete();
            exp_hw = 0;
        end else begin
            if (do_pop) begin
                void'(exp_q.pop_front());
                exp_xfer++;
            end
            if (do_push) begin
                exp_q.push_back(sd);
            end
            if (exp_q.size() > exp_hw) begin
                exp_hw = exp_q.size();
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [31:0] xb;
        rst         = 1'b1;
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        exp_hw      = 0;
        exp_xfer    = '0;

        // Reset state
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 1, 8'h77, 1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Fill with m_ready low
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, DW'(i), 0);
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        chk("full_hw", 32'(high_water), 32'd4);
        chk("full_head", 32'(bus.m_data), 32'h01);

        // Full: simultaneous push and pop pops only
        step(0, 0, 1, 8'hAA, 1);
        chk("full_pushpop_count", 32'(count), 32'd3);
        chk("full_pushpop_head", 32'(bus.m_data), 32'h02);

        // Flush with s_valid high at count=3
        xb = exp_xfer;
        step(0, 1, 1, 8'hBB, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_m_valid", 32'(bus.m_valid), 32'd0);
        chk("flush_hw", 32'(high_water), 32'd0);
        chk("flush_xfer", xfer_cnt, xb);

        // Steady state at count=2 for 20 cycles
        step(0, 0, 1, 8'h10, 0);
        step(0, 0, 1, 8'h11, 0);
        xb = exp_xfer;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, DW'(8'h12 + i), 1);
            chk("steady_count", 32'(count), 32'd2);
        end
        chk("steady_xfer", xfer_cnt, xb + 32'd20);
        chk("steady_head", 32'(bus.m_data), 32'h24);

        // Fill/drain rounds force pointers around the ring repeatedly
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                step(0, 0, 1, DW'($urandom), 0);
            end
            for (int i = 0; i < DEPTH; i++) begin
                step(0, 0, $urandom_range(0, 1) == 1, DW'($urandom), 1);
            end
        end

        // Random traffic with occasional flush
        for (int i = 0; i < 200; i++) begin
            step(0, $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                 DW'($urandom), $urandom_range(0, 2) != 0);
        end

        // Reset mid-stream with traffic present
        step(0, 0, 1, 8'h31, 0);
        step(0, 0, 1, 8'h32, 0);
        step(1, 0, 1, 8'h33, 1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_xfer", xfer_cnt, 32'd0);
        step(0, 0, 0, 8'h00, 0);
        chk("post_rst_hw", 32'(high_water), 32'd0);

        // Transfer counter wrap
        step(0, 0, 1, 8'h5A, 0);
        force dut.xfer_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.xfer_cnt_q;
        exp_xfer = 32'hFFFF_FFFF;
        #1;
        chk("xfer_preload", xfer_cnt, 32'hFFFF_FFFF);
        step(0, 0, 0, 8'h00, 1);
        chk("xfer_wrap", xfer_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
